// File: rtl/heartbeat_gen.sv
// Multi-channel heartbeat/blink generator: a shared prescaler tick drives NCH period counters.
// Each counter feeds one output in off/pulse/pwm/toggle mode. Optional HEARTBEAT_GEN_PHASE_EN adds per-channel start phase.
module heartbeat_gen #(
  parameter int N   = 8,
  parameter int NCH = 4,
  parameter int PSW = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sync,
  input  logic [PSW-1:0]   prescale,
  input  logic [NCH*N-1:0] period,
  input  logic [NCH*N-1:0] width,
  input  logic [2*NCH-1:0] mode,
`ifdef HEARTBEAT_GEN_PHASE_EN
  input  logic [NCH*N-1:0] phase,
`endif
  output logic             tick,
  output logic [NCH-1:0]   out
);

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_PULSE = 2'b01;
  localparam logic [1:0] MODE_PWM   = 2'b10;

  logic [PSW-1:0] pc;
  logic           wrap;
  logic           tick_i;

  // >= so that shrinking prescale below the running count wraps at once
  assign wrap   = (pc >= prescale);
  assign tick_i = en && !sync && wrap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc   <= '0;
      tick <= 1'b0;
    end else if (sync) begin
      pc   <= '0;
      tick <= 1'b0;
    end else if (en) begin
      if (wrap) begin
        pc   <= '0;
        tick <= 1'b1;
      end else begin
        pc   <= pc + 1'b1;
        tick <= 1'b0;
      end
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [N-1:0] cnt;
    logic [N-1:0] per;
    logic [N-1:0] wid;
    logic [N-1:0] load;
    logic [1:0]   md;
    logic         at_term;
    logic         o;

    assign per     = period[k*N +: N];
    assign wid     = width[k*N +: N];
    assign md      = mode[2*k +: 2];
    assign at_term = (cnt == per);

`ifdef HEARTBEAT_GEN_PHASE_EN
    logic [N-1:0] ph;
    logic         was_off;
    assign ph   = phase[k*N +: N];
    assign load = (ph < per) ? ph : per;
`else
    assign load = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt <= '0;
        o   <= 1'b0;
`ifdef HEARTBEAT_GEN_PHASE_EN
        was_off <= 1'b0;
`endif
      end else if (sync) begin
        cnt <= load;
        o   <= 1'b0;
`ifdef HEARTBEAT_GEN_PHASE_EN
        was_off <= (md == MODE_OFF);
`endif
      end else if (en) begin
        case (md)
          MODE_OFF:   o <= 1'b0;
          MODE_PULSE: o <= at_term;
          MODE_PWM:   o <= (cnt < wid);
          default:    if (tick_i && at_term) o <= ~o;
        endcase
        if (md == MODE_OFF) begin
          cnt <= '0;
`ifdef HEARTBEAT_GEN_PHASE_EN
        end else if (was_off) begin
          cnt <= load;
`endif
        end else if (tick_i) begin
          cnt <= (cnt >= per) ? '0 : cnt + 1'b1;
        end
`ifdef HEARTBEAT_GEN_PHASE_EN
        was_off <= (md == MODE_OFF);
`endif
      end
    end

    assign out[k] = o;
  end

endmodule

// File: tb/tb_heartbeat_gen.sv
// Self-checking bench for heartbeat_gen: per-cycle behavioural model plus directed literal checks.
// Also builds with HEARTBEAT_GEN_PHASE_EN to cover staggered start phases.
module tb_heartbeat_gen;
  localparam int N   = 8;
  localparam int NCH = 4;
  localparam int PSW = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic             sync;
  logic [PSW-1:0]   prescale;
  logic [NCH*N-1:0] period;
  logic [NCH*N-1:0] width;
  logic [2*NCH-1:0] mode;
`ifdef HEARTBEAT_GEN_PHASE_EN
  logic [NCH*N-1:0] phase;
`endif
  logic             tick;
  logic [NCH-1:0]   out;

  int n_pass = 0;
  int n_total = 0;
  bit armed = 1'b0;

  always #5 clk = ~clk;

  heartbeat_gen #(.N(N), .NCH(NCH), .PSW(PSW)) dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .sync(sync),
    .prescale(prescale),
    .period(period),
    .width(width),
    .mode(mode),
`ifdef HEARTBEAT_GEN_PHASE_EN
    .phase(phase),
`endif
    .tick(tick),
    .out(out)
  );

  // Model: position of each channel within its period, in ticks
  int m_pc = 0;
  bit m_tick = 1'b0;
  int m_cnt[NCH];
  bit m_out[NCH];
`ifdef HEARTBEAT_GEN_PHASE_EN
  bit m_off[NCH];
`endif

  function automatic int mf(input int k);
    return int'(mode[2*k +: 2]);
  endfunction
  function automatic int pf(input int k);
    return int'(period[k*N +: N]);
  endfunction
  function automatic int wf(input int k);
    return int'(width[k*N +: N]);
  endfunction
  function automatic bit m_wrap();
    return m_pc >= int'(prescale);
  endfunction

  function automatic int start_cnt(input int k);
`ifdef HEARTBEAT_GEN_PHASE_EN
    int ph = int'(phase[k*N +: N]);
    return (ph < pf(k)) ? ph : pf(k);
`else
    return k * 0;
`endif
  endfunction

  function automatic bit next_out(input int k);
    int c = m_cnt[k];
    case (mf(k))
      1:       return c == pf(k);
      2:       return c < wf(k);
      3:       return m_out[k] ^ (m_wrap() && c == pf(k));
      default: return 1'b0;
    endcase
  endfunction

  function automatic int next_cnt(input int k);
    int c = m_cnt[k];
    if (mf(k) == 0) return 0;
`ifdef HEARTBEAT_GEN_PHASE_EN
    if (m_off[k]) return start_cnt(k);
`endif
    if (!m_wrap()) return c;
    return (c < pf(k)) ? c + 1 : 0;
  endfunction

  function automatic logic [NCH-1:0] pack_out();
    logic [NCH-1:0] v = '0;
    for (int k = 0; k < NCH; k++) v[k] = m_out[k];
    return v;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc   <= 0;
      m_tick <= 1'b0;
      for (int k = 0; k < NCH; k++) begin
        m_cnt[k] <= 0;
        m_out[k] <= 1'b0;
`ifdef HEARTBEAT_GEN_PHASE_EN
        m_off[k] <= 1'b0;
`endif
      end
    end else if (sync) begin
      m_pc   <= 0;
      m_tick <= 1'b0;
      for (int k = 0; k < NCH; k++) begin
        m_cnt[k] <= start_cnt(k);
        m_out[k] <= 1'b0;
`ifdef HEARTBEAT_GEN_PHASE_EN
        m_off[k] <= (mf(k) == 0);
`endif
      end
    end else if (en) begin
      m_pc   <= m_wrap() ? 0 : m_pc + 1;
      m_tick <= m_wrap();
      for (int k = 0; k < NCH; k++) begin
        m_out[k] <= next_out(k);
        m_cnt[k] <= next_cnt(k);
`ifdef HEARTBEAT_GEN_PHASE_EN
        m_off[k] <= (mf(k) == 0);
`endif
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (armed && !reset)
      check("model_cycle", int'({tick, out}), int'({m_tick, pack_out()}));
  end

  task automatic set_ch(input int k, input int m, input int p, input int w);
    mode[2*k +: 2]  = 2'(m);
    period[k*N +: N] = N'(p);
    width[k*N +: N]  = N'(w);
  endtask

  task automatic step(input int c);
    repeat (c) @(negedge clk);
  endtask

  task automatic wait_out(input int k, input logic v, input int maxc, output int n);
    n = 0;
    while (out[k] !== v && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (out[k] !== v) begin
      n_total++;
      $display("FAIL wait_out ch%0d: level %0b not seen within %0d cycles", k, v, maxc);
    end
  endtask

  task automatic wait_tick(input int maxc, output int n);
    n = 0;
    while (tick !== 1'b1 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (tick !== 1'b1) begin
      n_total++;
      $display("FAIL wait_tick: tick not seen within %0d cycles", maxc);
    end
  endtask

  task automatic count_high(input int k, input int c, output int h);
    h = 0;
    repeat (c) begin
      if (out[k] === 1'b1) h++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    int h;
    int first[NCH];
    reset = 1'b0; en = 1'b0; sync = 1'b0; prescale = '0;
    period = '0; width = '0; mode = '0;
`ifdef HEARTBEAT_GEN_PHASE_EN
    phase = '0;
`endif
    #1 reset = 1'b1;
    step(3);
    check("reset_tick", int'(tick), 0);
    check("reset_out", int'(out), 0);

    // Legacy heartbeat: first rise at the 256th edge after release
    prescale = 8'd0;
    set_ch(0, 1, 255, 0);
    en = 1'b1;
    reset = 1'b0;
    armed = 1'b1;
    wait_out(0, 1'b1, 400, n); check("legacy_first_rise", n, 256);
    wait_out(0, 1'b0, 10, n);  check("legacy_high_len", n, 1);
    wait_out(0, 1'b1, 400, n); check("legacy_low_len", n, 255);

    // PWM: tick every 4 clk, 3 of 10 ticks high
    prescale = 8'd3;
    set_ch(1, 2, 9, 3);
    sync = 1'b1; step(1); sync = 1'b0;
    check("sync_clears_out", int'(out), 0);
    wait_out(1, 1'b1, 50, n); check("pwm_first", n, 1);
    wait_out(1, 1'b0, 50, n); check("pwm_high", n, 12);
    wait_out(1, 1'b1, 50, n); check("pwm_low", n, 28);
    set_ch(1, 2, 9, 0); step(1);
    count_high(1, 40, h); check("pwm_width0", h, 0);
    set_ch(1, 2, 9, 15); step(1);
    count_high(1, 40, h); check("pwm_width_gt_period", h, 40);

    // Toggle: half period 5 ticks of 2 clk; freeze with en=0 for 7 cycles
    prescale = 8'd1;
    set_ch(2, 3, 4, 0);
    sync = 1'b1; step(1); sync = 1'b0;
    wait_out(2, 1'b1, 50, n); check("toggle_first", n, 10);
    wait_out(2, 1'b0, 50, n); check("toggle_half1", n, 10);
    wait_out(2, 1'b1, 50, n); check("toggle_half2", n, 10);
    step(4);
    en = 1'b0;
    step(7);
    check("freeze_tick_held", int'(tick), 1);
    check("freeze_out_held", int'(out[2]), 1);
    en = 1'b1;
    wait_out(2, 1'b0, 50, n); check("toggle_resume_shift", n, 6);

    // Dynamic period: cnt=200, shrink period to 50
    prescale = 8'd0;
    set_ch(0, 1, 255, 0);
    sync = 1'b1; step(1); sync = 1'b0;
    step(200);
    set_ch(0, 1, 50, 0);
    wait_out(0, 1'b1, 100, n); check("dyn_first_rise", n, 52);
    wait_out(0, 1'b0, 10, n);  check("dyn_high_len", n, 1);
    wait_out(0, 1'b1, 100, n); check("dyn_low_len", n, 50);

    // sync with en=0 while channels are mid-count and ch1 is high
    prescale = 8'd3;
    step(5);
    check("pre_sync_ch1_high", int'(out[1]), 1);
    en = 1'b0; sync = 1'b1; step(1); sync = 1'b0;
    check("sync_en0_out", int'(out), 0);
    check("sync_en0_tick", int'(tick), 0);
    step(2);
    check("sync_en0_hold", int'(out), 0);
    en = 1'b1;
    wait_tick(20, n); check("first_tick_after_sync", n, 4);

    // Staggered start (phase 0,2,4,6 when the phase build is enabled)
    prescale = 8'd0;
    for (int k = 0; k < NCH; k++) begin
      set_ch(k, 1, 7, 0);
      first[k] = -1;
`ifdef HEARTBEAT_GEN_PHASE_EN
      phase[k*N +: N] = N'(2 * k);
`endif
    end
    step(2);
    sync = 1'b1; step(1); sync = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      for (int k = 0; k < NCH; k++)
        if (out[k] === 1'b1 && first[k] < 0) first[k] = c;
    end
`ifdef HEARTBEAT_GEN_PHASE_EN
    check("stagger_ch0", first[0], 8);
    check("stagger_ch1", first[1], 6);
    check("stagger_ch2", first[2], 4);
    check("stagger_ch3", first[3], 2);
`else
    check("aligned_ch0", first[0], 8);
    check("aligned_ch1", first[1], 8);
    check("aligned_ch2", first[2], 8);
    check("aligned_ch3", first[3], 8);
`endif

    // Async reset between edges
    set_ch(1, 2, 9, 15);
    step(3);
    check("pre_reset_tick", int'(tick), 1);
    check("pre_reset_ch1", int'(out[1]), 1);
    #2 reset = 1'b1;
    #1;
    check("async_reset_tick", int'(tick), 0);
    check("async_reset_out", int'(out), 0);
    @(negedge clk);
    for (int k = 1; k < NCH; k++) set_ch(k, 0, 0, 0);
    set_ch(0, 1, 255, 0);
    reset = 1'b0;
    wait_out(0, 1'b1, 400, n); check("restart_first_rise", n, 256);
    wait_out(0, 1'b0, 10, n);  check("restart_high_len", n, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/heartbeat_gen.md
Name: heartbeat_gen

Overview:
Multi-channel, parametrised heartbeat and blink generator. It is the successor to the fixed single-output, power-of-two heartbeat.
- A shared prescaler produces a tick strobe.
- Each of NCH channels runs its own period counter on that tick and drives one output in one of four modes: off, pulse, PWM or toggle.
- Used for status LEDs, watchdog kicks and periodic strobes to other blocks.

Parameters:
- N, 8, channel counter width in bits; period and width fields are N bits each.
- NCH, 4, number of independent output channels (minimum 1).
- PSW, 8, prescaler counter width in bits.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-high reset
- en  input  1  global run enable; when low, all counters and outputs hold
- sync  input  1  synchronous restart of prescaler and all channels
- prescale  input  PSW  tick interval minus 1, in clk cycles
- period  input  NCH*N  per-channel terminal count; channel k uses [k*N +: N]
- width  input  NCH*N  per-channel PWM high time in ticks
- mode  input  2*NCH  per-channel mode, channel k uses [2k +: 2]: 00 off, 01 pulse, 10 pwm, 11 toggle
- tick  output  1  registered prescaler strobe
- out  output  NCH  registered per-channel heartbeat outputs

Behaviour:
- Reset (async assert, sync release by design): prescaler=0, all channel counters=0, tick=0, out=0.
- Prescaler pc:
  - When en=1: if pc==prescale then pc<=0 and tick<=1; else pc<=pc+1 and tick<=0.
  - prescale=0 gives tick=1 every cycle while en=1.
  - A prescale change below the current pc takes the pc>=prescale branch: wrap to 0 and assert tick. The compare is >=, not ==.
- Channel counter cnt[k] advances only in cycles where the prescaler wraps (internal tick_i, same cycle as pc wrap):
  - cnt>=period gives cnt<=0, otherwise cnt<=cnt+1.
  - Period of the channel = period+1 ticks. period=0 gives cnt stuck at 0, terminal every tick.
  - Lowering period below the current cnt wraps cnt to 0 on the next tick.
- Outputs are registered and update every clk while en=1, one cycle after the counter state they decode:
  - mode 00 (off): out[k]<=0; cnt[k] held at 0.
  - mode 01 (pulse): out[k]<=(cnt[k]==period[k]). High for one full tick interval per period. With prescale=0 and period=2^N-1 this is cycle-identical to the legacy heartbeat.
  - mode 10 (pwm): out[k]<=(cnt[k]<width[k]). width=0 gives constant 0; width>period gives constant 1.
  - mode 11 (toggle): out[k] inverts on each tick_i with cnt[k]==period[k]. Output period = 2*(period+1) ticks.
- Mode change: takes effect on the next clk and does not reset cnt, except entering 00, which clears it. Leaving toggle keeps no state; re-entering toggle resumes from the current out value.
- en=0: pc, cnt, tick and out all hold their values. tick holds, so software must not treat a held tick as a new event. Resuming continues seamlessly.
- sync=1 (priority over en): pc<=0, all cnt<=0, out<=0, tick<=0. The first tick after release occurs prescale+1 cycles later if en=1.
- Simultaneous sync and counter wrap: sync wins.
- All arithmetic is unsigned. Counters never exceed 2^N-1 or 2^PSW-1.

Optional Feature:
Macro HEARTBEAT_GEN_PHASE_EN.
- Defined:
  - Adds input phase (NCH*N).
  - On sync, and on leaving mode 00, cnt[k] loads min(phase[k], period[k]) instead of 0. This allows staggered channels.
  - Reset still clears cnt to 0.
- Not defined:
  - The phase port is absent.
  - All loads use 0.

Test Plan:
1. Legacy equivalence: N=8, prescale=0, ch0 mode=01, period=255, en=1, release reset → out[0] first high on cycle 257 after release, high 1 cycle, repeats every 256 cycles.
2. PWM: prescale=3, period=9, width=3 → tick every 4 clk; out high 12 clk, low 28 clk, repeating. Then width=0 → constant 0; width=15 → constant 1.
3. Toggle: prescale=1, period=4, mode=11 → out toggles every 10 clk (period 20 clk). en=0 for 7 cycles mid-run → out and tick frozen, then resume with the phase shifted by exactly 7.
4. Dynamic period: ch0 running with cnt=200 and period=255; write period=50 → on the next tick cnt=0, then the period is 51 ticks.
5. sync with en=0 and channels mid-count → all out=0, cnt=0 next cycle. With HEARTBEAT_GEN_PHASE_EN and phase={0,2,4,6}, period=7 in pulse mode, the four channels pulse staggered by 2 ticks.
6. Async reset asserted mid-cycle between clk edges → out and tick go 0 immediately without a clock edge; after release, behaviour matches the fresh start in test 1.
